// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM-stage port and a DMA/debug port.
// CPU wins by default; a saturating starvation counter forces a DMA grant after MAX_WAIT denials.
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CW       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_a,
    input  logic [31:0] dma_wd,
    output logic [31:0] dma_rd,
    output logic        dma_ack,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
    } mem_req_t;

    localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] starve;
    logic          force_dma;
    logic          gnt_dma;
    logic          gnt_cpu;
    mem_req_t      cpu_mreq;
    mem_req_t      dma_mreq;
    mem_req_t      mem_mreq;

    assign cpu_mreq = '{we: cpu_we, a: cpu_a, wd: cpu_wd};
    assign dma_mreq = '{we: dma_we, a: dma_a, wd: dma_wd};

    // Grants are suppressed while reset is held so nothing reaches dmem.
    assign force_dma = (starve == STARVE_MAX);
    assign gnt_dma   = ~reset & dma_req & (~cpu_req | force_dma);
    assign gnt_cpu   = ~reset & cpu_req & ~gnt_dma;

    always_comb begin
        mem_mreq = '0;
        if (gnt_dma)
            mem_mreq = dma_mreq;
        else if (gnt_cpu)
            mem_mreq = cpu_mreq;
    end

    assign mem_we    = mem_mreq.we;
    assign mem_a     = mem_mreq.a;
    assign mem_wd    = mem_mreq.wd;

    assign cpu_rd    = mem_rd;
    assign dma_rd    = mem_rd;
    assign cpu_stall = ~reset & cpu_req & ~gnt_cpu;
    assign dma_ack   = gnt_dma;

    // Dropping the DMA request forfeits any accumulated wait.
    always_ff @(posedge clk) begin
        if (reset)
            starve <= '0;
        else if (!dma_req || gnt_dma)
            starve <= '0;
        else if (starve != STARVE_MAX)
            starve <= starve + CW'(1);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MAX_WAIT=4, one at MAX_WAIT=1, each with a small RAM.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- instance A: MAX_WAIT = 4 ----------------
    logic        reset_a, cpu_req_a, cpu_we_a, dma_req_a, dma_we_a;
    logic [31:0] cpu_a_a, cpu_wd_a, dma_a_a, dma_wd_a;
    logic [31:0] cpu_rd_a, dma_rd_a, mem_a_a, mem_wd_a, mem_rd_a;
    logic        cpu_stall_a, dma_ack_a, mem_we_a;
    logic [31:0] ram_a [0:15];

    dmem_arbiter #(.MAX_WAIT(4), .CW(8)) dut_a (
        .clk(clk), .reset(reset_a),
        .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_a(cpu_a_a), .cpu_wd(cpu_wd_a),
        .cpu_rd(cpu_rd_a), .cpu_stall(cpu_stall_a),
        .dma_req(dma_req_a), .dma_we(dma_we_a), .dma_a(dma_a_a), .dma_wd(dma_wd_a),
        .dma_rd(dma_rd_a), .dma_ack(dma_ack_a),
        .mem_we(mem_we_a), .mem_a(mem_a_a), .mem_wd(mem_wd_a), .mem_rd(mem_rd_a)
    );

    assign mem_rd_a = ram_a[mem_a_a[5:2]];
    always @(posedge clk) if (mem_we_a) ram_a[mem_a_a[5:2]] <= mem_wd_a;

    // ---------------- instance B: MAX_WAIT = 1 ----------------
    logic        reset_b, cpu_req_b, cpu_we_b, dma_req_b, dma_we_b;
    logic [31:0] cpu_a_b, cpu_wd_b, dma_a_b, dma_wd_b;
    logic [31:0] cpu_rd_b, dma_rd_b, mem_a_b, mem_wd_b, mem_rd_b;
    logic        cpu_stall_b, dma_ack_b, mem_we_b;
    logic [31:0] ram_b [0:15];

    dmem_arbiter #(.MAX_WAIT(1), .CW(4)) dut_b (
        .clk(clk), .reset(reset_b),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_a(cpu_a_b), .cpu_wd(cpu_wd_b),
        .cpu_rd(cpu_rd_b), .cpu_stall(cpu_stall_b),
        .dma_req(dma_req_b), .dma_we(dma_we_b), .dma_a(dma_a_b), .dma_wd(dma_wd_b),
        .dma_rd(dma_rd_b), .dma_ack(dma_ack_b),
        .mem_we(mem_we_b), .mem_a(mem_a_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd_b)
    );

    assign mem_rd_b = ram_b[mem_a_b[5:2]];
    always @(posedge clk) if (mem_we_b) ram_b[mem_a_b[5:2]] <= mem_wd_b;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_a[i] = 32'h0;
            ram_b[i] = 32'h0;
        end
        reset_a = 1'b1; cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_a_a = 32'h10; cpu_wd_a = 32'hAA;
        dma_req_a = 1'b1; dma_we_a = 1'b1; dma_a_a = 32'h14; dma_wd_a = 32'hBB;
        reset_b = 1'b1; cpu_req_b = 1'b0; cpu_we_b = 1'b0; cpu_a_b = 32'h0; cpu_wd_b = 32'h0;
        dma_req_b = 1'b0; dma_we_b = 1'b0; dma_a_b = 32'h0; dma_wd_b = 32'h0;
        #2;

        // Reset holds off every grant even with both ports requesting writes.
        for (int c = 0; c < 2; c++) begin
            chk("rst_mem_we", 32'(mem_we_a), 32'd0);
            chk("rst_stall", 32'(cpu_stall_a), 32'd0);
            chk("rst_ack", 32'(dma_ack_a), 32'd0);
            chk("rst_mem_a", mem_a_a, 32'd0);
            chk("rst_mem_wd", mem_wd_a, 32'd0);
            step();
        end
        reset_a = 1'b0; reset_b = 1'b0;
        cpu_req_a = 1'b0; dma_req_a = 1'b0;
        chk("rst_starve", 32'(dut_a.starve), 32'd0);
        chk("rst_ram_untouched", ram_a[4], 32'd0);
        step();
        chk("idle_starve", 32'(dut_a.starve), 32'd0);

        // CPU write to 0x4, then DMA reads it back.
        cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_a_a = 32'h4; cpu_wd_a = 32'h99;
        #1;
        chk("cpuw_mem_we", 32'(mem_we_a), 32'd1);
        chk("cpuw_stall", 32'(cpu_stall_a), 32'd0);
        chk("cpuw_mem_a", mem_a_a, 32'h4);
        chk("cpuw_mem_wd", mem_wd_a, 32'h99);
        step();
        chk("cpuw_ram", ram_a[1], 32'h99);
        cpu_req_a = 1'b0; cpu_we_a = 1'b0;
        dma_req_a = 1'b1; dma_we_a = 1'b0; dma_a_a = 32'h4;
        #1;
        chk("dmar_ack", 32'(dma_ack_a), 32'd1);
        chk("dmar_rd", dma_rd_a, 32'h99);
        chk("dmar_mem_we", 32'(mem_we_a), 32'd0);
        step();

        // Continuous contention: period 5, DMA on cycles 4 and 9.
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_a_a = 32'h0;
        dma_req_a = 1'b1; dma_we_a = 1'b0; dma_a_a = 32'h8;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("cont_ack_c%0d", c), 32'(dma_ack_a), (c == 4 || c == 9) ? 32'd1 : 32'd0);
            chk($sformatf("cont_stall_c%0d", c), 32'(cpu_stall_a), (c == 4 || c == 9) ? 32'd1 : 32'd0);
            chk($sformatf("cont_mem_a_c%0d", c), mem_a_a, (c == 4 || c == 9) ? 32'h8 : 32'h0);
            chk($sformatf("cont_starve_c%0d", c), 32'(dut_a.starve), 32'(c % 5));
            step();
        end

        // Withdraw after two denials forfeits the wait; reassert needs four fresh denials.
        for (int c = 0; c < 2; c++) begin
            chk("wd_ack_pre", 32'(dma_ack_a), 32'd0);
            step();
        end
        chk("wd_starve2", 32'(dut_a.starve), 32'd2);
        dma_req_a = 1'b0;
        step();
        chk("wd_starve0", 32'(dut_a.starve), 32'd0);
        dma_req_a = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("wd_ack_c%0d", c), 32'(dma_ack_a), (c == 4) ? 32'd1 : 32'd0);
            step();
        end

        // Reset at starve=3 discards the wait.
        for (int c = 0; c < 3; c++) step();
        chk("rmid_starve3", 32'(dut_a.starve), 32'd3);
        reset_a = 1'b1;
        #1;
        chk("rmid_ack", 32'(dma_ack_a), 32'd0);
        chk("rmid_stall", 32'(cpu_stall_a), 32'd0);
        step();
        reset_a = 1'b0;
        chk("rmid_starve0", 32'(dut_a.starve), 32'd0);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rmid_ack_c%0d", c), 32'(dma_ack_a), (c == 4) ? 32'd1 : 32'd0);
            step();
        end
        cpu_req_a = 1'b0; dma_req_a = 1'b0;

        // MAX_WAIT=1: forced DMA write to 0x8 lands between CPU reads.
        ram_b[2] = 32'h11;
        cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_a_b = 32'h8;
        dma_req_b = 1'b1; dma_we_b = 1'b1; dma_a_b = 32'h8; dma_wd_b = 32'h55;
        #1;
        chk("mw1_c0_stall", 32'(cpu_stall_b), 32'd0);
        chk("mw1_c0_ack", 32'(dma_ack_b), 32'd0);
        chk("mw1_c0_rd", cpu_rd_b, 32'h11);
        step();
        chk("mw1_c1_stall", 32'(cpu_stall_b), 32'd1);
        chk("mw1_c1_ack", 32'(dma_ack_b), 32'd1);
        chk("mw1_c1_mem_we", 32'(mem_we_b), 32'd1);
        chk("mw1_c1_mem_wd", mem_wd_b, 32'h55);
        step();
        dma_req_b = 1'b0; dma_we_b = 1'b0;
        #1;
        chk("mw1_c2_stall", 32'(cpu_stall_b), 32'd0);
        chk("mw1_c2_rd", cpu_rd_b, 32'h55);
        chk("mw1_ram", ram_b[2], 32'h55);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory `dmem` between the pipelined CPU's MEM-stage data port and a secondary DMA/debug port. The CPU has default priority. A starvation counter guarantees the DMA port a grant after at most `MAX_WAIT` consecutive denied cycles. When the CPU is denied, the block asserts a stall back to the pipeline. It sits between the CPU/DMA master ports and `dmem` (`clk`, `we`, `a`, `wd`, `rd`).

## Interface

**Parameters**
- `MAX_WAIT`, default 4: consecutive denied DMA cycles after which DMA is forced to priority. Legal range 1..255.
- `CW`, default 8: starvation counter width. Must satisfy 2^CW > MAX_WAIT.

**Ports**
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU requests a memory access this cycle.
- `cpu_we` in 1: CPU access is a write.
- `cpu_a` in 32: CPU byte address.
- `cpu_wd` in 32: CPU write data.
- `cpu_rd` out 32: CPU read data.
- `cpu_stall` out 1: CPU request denied this cycle; pipeline must hold.
- `dma_req` in 1: DMA requests a memory access this cycle.
- `dma_we` in 1: DMA access is a write.
- `dma_a` in 32: DMA byte address.
- `dma_wd` in 32: DMA write data.
- `dma_rd` out 32: DMA read data.
- `dma_ack` out 1: DMA access performed this cycle.
- `mem_we` out 1: to `dmem` `we`.
- `mem_a` out 32: to `dmem` `a`.
- `mem_wd` out 32: to `dmem` `wd`.
- `mem_rd` in 32: from `dmem` `rd`.

## Operation

- **Grant decision** (combinational, per cycle) is computed from `cpu_req`, `dma_req` and the registered counter `starve`:
  - `force = (starve == MAX_WAIT)`.
  - `gnt_dma = dma_req & (~cpu_req | force)`.
  - `gnt_cpu = cpu_req & ~gnt_dma`.
- **Memory mux:**
  - The granted port's `we`/`a`/`wd` drive `mem_*`.
  - With no grant: `mem_we=0`, `mem_a=0`, `mem_wd=0`.
  - Addresses pass through unmodified; `dmem` word-indexes with `a[31:2]`.
- **Read data:**
  - `mem_rd` fans out to both `cpu_rd` and `dma_rd` unconditionally.
  - It is meaningful only to the granted port.
- **Handshake outputs:**
  - `cpu_stall = cpu_req & ~gnt_cpu`.
  - `dma_ack = gnt_dma`.
  - A denied requester must hold `req`, `we`, `a` and `wd` stable until granted.
- **Starvation counter `starve`** (CW bits, registered):
  - `dma_req & ~gnt_dma` → `starve+1`, saturating at `MAX_WAIT`.
  - `gnt_dma` → 0.
  - `~dma_req` → 0. Withdrawing the request forfeits accumulated wait.
- **Reset:**
  - While `reset=1`, all grants are forced to 0: `mem_we=0`, `cpu_stall=0`, `dma_ack=0`, `mem_a=0`, `mem_wd=0`.
  - `starve` loads 0 at the clock edge.
  - Reset mid-contention discards accumulated wait.
- **Simultaneous events:**
  - Both requesting with `starve<MAX_WAIT` → CPU is granted and DMA waits.
  - Both requesting with `starve==MAX_WAIT` → DMA is granted and the CPU stalls exactly one cycle.
  - Both ports writing the same address is impossible in one cycle; only one port is granted.

## Timing

- **Grant, mux, stall and ack** are combinational in the same cycle as the request. There are no added cycles of latency.
- **Read:** `dmem` read is asynchronous, so `*_rd` is valid in the same cycle as the grant and the requester samples it at the next rising edge.
- **Write:** commits to `dmem` at the rising edge ending the granted cycle.
- **`starve`:** updates on the rising edge; the forced grant takes effect in the cycle after the counter reaches `MAX_WAIT`.
- **Worst-case DMA latency** under continuous CPU traffic is `MAX_WAIT` denied cycles, then the grant on cycle `MAX_WAIT+1`.
- **Steady-state pattern** with both requesting continuously has period `MAX_WAIT+1`: `MAX_WAIT` CPU grants, then 1 DMA grant.
- **Reset values:** `starve=0`; all outputs are 0 while `reset` is high except `cpu_rd`/`dma_rd`, which follow `mem_rd`.

## Test plan

- **Reset:** `reset=1`, both `req=1`, `we=1` → `mem_we=0`, `cpu_stall=0`, `dma_ack=0` every cycle. After release with `dma_req=0`, `starve=0`.
- **CPU write then DMA read:**
  - CPU only, `cpu_we=1`, `cpu_a=0x4`, `cpu_wd=0x99` → `mem_we=1` and `cpu_stall=0` in the same cycle; `RAM[1]=0x99` after the edge.
  - Next cycle, DMA only, read `0x4` → `dma_ack=1`, `dma_rd=0x99` in the same cycle.
- **Contention, `MAX_WAIT=4`:**
  - Both request continuously from cycle 0 → `gnt_cpu` on cycles 0–3.
  - Cycle 4: `dma_ack=1`, `cpu_stall=1`.
  - Cycles 5–8: CPU. Cycle 9: DMA again.
- **DMA withdraw:**
  - Both request; drop `dma_req` after 2 denied cycles → `starve=0`.
  - Reassert → DMA granted only after 4 further denied cycles.
- **Reset mid-contention:**
  - Assert reset for 1 cycle at `starve=3` → `starve=0`.
  - The DMA forced grant occurs 4 denied cycles after reset release, not 1.
- **DMA forced write vs. CPU read** (same address `0x8`, `MAX_WAIT=1`):
  - Both requesting; CPU granted on the first cycle, then DMA write `0x55` forced on the second.
  - CPU stalls one cycle, then reads `0x55`.
